// File: rtl/imm_gen_pipe_pkg.sv
// Purpose: shared RV32 opcode constants and immediate-format codes for the decode stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Purpose: fetch-side and execute-side handshake bundle of the immediate generator.
// Latency: n/a (wiring only).
// Backpressure: in_ready / out_ready valid-ready pairs; flush travels with the fetch side.
// Ports: in_valid/in_ready/in_instr/in_pc/flush (fetch -> block),
//        out_valid/out_ready/out_imm/out_fmt/out_illegal/out_pc (block -> execute).
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    import rv32_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    fmt_e             out_fmt;
    logic             out_illegal;
    logic [XLEN-1:0]  out_pc;

    // slave: the immediate generator itself
    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc
    );

    // master: the surrounding pipeline (fetch + execute)
    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc
    );

endinterface

// File: rtl/imm_gen_pipe_decode.sv
// Purpose: combinational RV32I immediate decode (instr -> imm, fmt, illegal).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the wrapping pipe owns all flow control.
// Ports: i_instr (raw word) -> o_imm (XLEN), o_fmt (fmt_e), o_illegal.
module imm_decode
    import rv32_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit SIGN_EXT = 1'b1
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output fmt_e            o_fmt,
    output logic            o_illegal
);

    // Upper-bit fill for every signed format; zero when sign extension is off.
    logic [XLEN-1:0] w_ext;
    assign w_ext = (SIGN_EXT && i_instr[31]) ? {XLEN{1'b1}} : {XLEN{1'b0}};

    // Each format starts from the fill pattern and overwrites its low field,
    // which keeps the slices valid for any XLEN >= 32.
    always_comb begin
        o_imm     = '0;
        o_fmt     = FMT_ILL;
        o_illegal = 1'b1;
        case (i_instr[6:0])
            OP_R: begin
                o_fmt     = FMT_R;
                o_illegal = 1'b0;
            end
            OP_LOAD, OP_IMM, OP_JALR, OP_SYS: begin
                o_imm        = w_ext;
                o_imm[11:0]  = i_instr[31:20];
                o_fmt        = FMT_I;
                o_illegal    = 1'b0;
            end
            OP_STORE: begin
                o_imm        = w_ext;
                o_imm[11:0]  = {i_instr[31:25], i_instr[11:7]};
                o_fmt        = FMT_S;
                o_illegal    = 1'b0;
            end
            OP_BRANCH: begin
                o_imm        = w_ext;
                o_imm[11:0]  = {i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
                o_fmt        = FMT_B;
                o_illegal    = 1'b0;
            end
            OP_LUI, OP_AUIPC: begin
                o_imm        = w_ext;
                o_imm[31:0]  = {i_instr[31:12], 12'b0};
                o_fmt        = FMT_U;
                o_illegal    = 1'b0;
            end
            OP_JAL: begin
                o_imm        = w_ext;
                o_imm[19:0]  = {i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
                o_fmt        = FMT_J;
                o_illegal    = 1'b0;
            end
            default: begin
                o_imm     = '0;
                o_fmt     = FMT_ILL;
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Purpose: registered immediate generator with PC pass-through and flush, decode stage.
// Latency: 1 cycle from input handshake to out_valid.
// Backpressure: 2-entry skid, in_ready is a flop (no in<->out comb path); out_* stable while stalled.
// Ports: clk, rst_n (async active-low), bus (imm_gen_pipe_if.slave).
module imm_gen_pipe
    import rv32_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit SIGN_EXT = 1'b1,
    parameter bit SKID     = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    imm_gen_pipe_if.slave  bus
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0] w_dec_imm;
    fmt_e            w_dec_fmt;
    logic            w_dec_ill;
    entry_t          w_in_ent;

    imm_decode #(
        .XLEN     (XLEN),
        .SIGN_EXT (SIGN_EXT)
    ) u_decode (
        .i_instr   (bus.in_instr),
        .o_imm     (w_dec_imm),
        .o_fmt     (w_dec_fmt),
        .o_illegal (w_dec_ill)
    );

    assign w_in_ent = '{imm: w_dec_imm, fmt: w_dec_fmt, illegal: w_dec_ill, pc: bus.in_pc};

    // entry0 drives out_*, entry1 is the skid slot
    logic   r_v0, r_v1, r_in_rdy;
    entry_t r_e0, r_e1;

    logic w_in_rdy, w_in_fire, w_out_fire;
    logic w_n_v0, w_n_v1, w_ld0_in, w_ld0_e1, w_ld1;

    generate
        if (SKID) begin : g_skid
            assign w_in_rdy = r_in_rdy;
        end else begin : g_noskid
            assign w_in_rdy = !r_v0 || bus.out_ready;
        end
    endgenerate

    assign w_in_fire  = bus.in_valid && w_in_rdy;
    assign w_out_fire = r_v0 && bus.out_ready;

    // Flush outranks everything, including an input handshake in the same cycle.
    always_comb begin
        w_n_v0   = r_v0;
        w_n_v1   = r_v1;
        w_ld0_in = 1'b0;
        w_ld0_e1 = 1'b0;
        w_ld1    = 1'b0;
        if (bus.flush) begin
            w_n_v0 = 1'b0;
            w_n_v1 = 1'b0;
        end else if (w_out_fire) begin
            if (r_v1) begin
                // skid refills the head; in_ready was low so no input this cycle
                w_ld0_e1 = 1'b1;
                w_n_v1   = 1'b0;
            end else if (w_in_fire) begin
                w_ld0_in = 1'b1;
            end else begin
                w_n_v0 = 1'b0;
            end
        end else if (w_in_fire) begin
            if (!r_v0) begin
                w_ld0_in = 1'b1;
                w_n_v0   = 1'b1;
            end else begin
                w_ld1  = 1'b1;
                w_n_v1 = SKID;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0         <= 1'b0;
            r_v1         <= 1'b0;
            r_in_rdy     <= 1'b1;
            r_e0.imm     <= '0;
            r_e0.fmt     <= FMT_R;
            r_e0.illegal <= 1'b0;
            r_e0.pc      <= '0;
        end else begin
            r_v0     <= w_n_v0;
            r_v1     <= w_n_v1;
            // registered copy of !v1 so in_ready never depends on out_ready
            r_in_rdy <= !w_n_v1;
            if (w_ld0_in) begin
                r_e0 <= w_in_ent;
            end else if (w_ld0_e1) begin
                r_e0 <= r_e1;
            end
        end
    end

    // skid data needs no reset: it is only observed through r_v1
    always_ff @(posedge clk) begin
        if (w_ld1) begin
            r_e1 <= w_in_ent;
        end
    end

    assign bus.in_ready    = w_in_rdy;
    assign bus.out_valid   = r_v0;
    assign bus.out_imm     = r_e0.imm;
    assign bus.out_fmt     = r_e0.fmt;
    assign bus.out_illegal = r_e0.illegal;
    assign bus.out_pc      = r_e0.pc;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Purpose: scoreboard bench for imm_gen_pipe (sign-extending and zero-extending instances).
// Latency: expects each accepted instruction on out_* one cycle after acceptance, in order.
// Backpressure: drives stalls, flush, async reset mid-stall and a random valid/ready soak.
module tb_imm_gen_pipe;
    import rv32_pkg::*;

    logic clk;
    logic rst_n;

    imm_gen_pipe_if #(.XLEN(32)) b ();
    imm_gen_pipe_if #(.XLEN(32)) b2 ();

    imm_gen_pipe #(.XLEN(32), .SIGN_EXT(1'b1), .SKID(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    imm_gen_pipe #(.XLEN(32), .SIGN_EXT(1'b0), .SKID(1'b1)) dut_zx (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] imm;
        fmt_e        fmt;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    exp_t q2[$];
    int   checks = 0;
    int   errors = 0;
    bit   soak_on;

    // directed vectors with hand-computed immediates
    logic [31:0] v_ins [12];
    logic [31:0] v_imm [12];
    fmt_e        v_fmt [12];
    logic        v_ill [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Holds in_valid until accepted; expectation is queued at the accepting edge.
    task automatic send(input int k, input logic [31:0] pc);
        bit fire;
        int waits;
        fire  = 1'b0;
        waits = 0;
        b.in_valid = 1'b1;
        b.in_instr = v_ins[k];
        b.in_pc    = pc;
        while (!fire) begin
            @(negedge clk);
            fire = b.in_ready && !b.flush && rst_n;
            @(posedge clk);
            if (fire) q.push_back('{v_imm[k], v_fmt[k], v_ill[k], pc});
            #1;
            if (!fire) begin
                waits++;
                if (waits > 50) begin
                    chk("in_ready_timeout", 64'd0, 64'd1);
                    break;
                end
            end
        end
        b.in_valid = 1'b0;
    endtask

    task automatic send2(input logic [31:0] ins, input logic [31:0] imm, input fmt_e f);
        bit fire;
        b2.in_valid = 1'b1;
        b2.in_instr = ins;
        b2.in_pc    = 32'h0000_2000;
        @(negedge clk);
        fire = b2.in_ready;
        @(posedge clk);
        if (fire) q2.push_back('{imm, f, 1'b0, 32'h0000_2000});
        else chk("zx_in_ready", 64'd0, 64'd1);
        #1;
        b2.in_valid = 1'b0;
    endtask

    // monitor for the sign-extending instance
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            chk("out_valid", b.out_valid, q.size() != 0);
            chk("in_ready", b.in_ready, q.size() < 2);
            if (b.out_valid && q.size() != 0) begin
                chk("out_imm", b.out_imm, q[0].imm);
                chk("out_fmt", b.out_fmt, q[0].fmt);
                chk("out_illegal", b.out_illegal, q[0].ill);
                chk("out_pc", b.out_pc, q[0].pc);
                if (b.out_ready && !b.flush) void'(q.pop_front());
            end
            if (b.flush) q.delete();
        end
    end

    // monitor for the zero-extending instance (always ready)
    always @(negedge clk) begin
        if (!rst_n) begin
            q2.delete();
        end else begin
            chk("zx_out_valid", b2.out_valid, q2.size() != 0);
            if (b2.out_valid && q2.size() != 0) begin
                chk("zx_out_imm", b2.out_imm, q2[0].imm);
                chk("zx_out_fmt", b2.out_fmt, q2[0].fmt);
                void'(q2.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        v_ins = '{32'hFFF00093, 32'h00112623, 32'hFE000EE3, 32'h12345037,
                  32'hFF9FF06F, 32'h0000007F, 32'h002081B3, 32'h00001517,
                  32'h00008067, 32'h00000073, 32'hFFC42503, 32'h00B51463};
        v_imm = '{32'hFFFFFFFF, 32'h0000000C, 32'hFFFFFFFC, 32'h12345000,
                  32'hFFFFFFF8, 32'h00000000, 32'h00000000, 32'h00001000,
                  32'h00000000, 32'h00000000, 32'hFFFFFFFC, 32'h00000008};
        v_fmt = '{FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL,
                  FMT_R, FMT_U, FMT_I, FMT_I, FMT_I, FMT_B};
        v_ill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n       = 1'b0;
        b.in_valid  = 1'b0;
        b.in_instr  = '0;
        b.in_pc     = '0;
        b.flush     = 1'b0;
        b.out_ready = 1'b1;
        b2.in_valid = 1'b0;
        b2.in_instr = '0;
        b2.in_pc    = '0;
        b2.flush    = 1'b0;
        b2.out_ready = 1'b1;

        // reset state
        #12;
        chk("rst_out_valid", b.out_valid, 1'b0);
        chk("rst_out_imm", b.out_imm, 32'd0);
        chk("rst_out_fmt", b.out_fmt, FMT_R);
        chk("rst_out_illegal", b.out_illegal, 1'b0);
        chk("rst_out_pc", b.out_pc, 32'd0);
        chk("rst_in_ready", b.in_ready, 1'b1);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // all formats back to back with no stall
        for (int i = 0; i < 12; i++) send(i, 32'h0000_1000 + 32'(i * 4));
        repeat (3) @(posedge clk);
        #1;

        // zero-extending instance
        send2(32'hFFF00093, 32'h00000FFF, FMT_I);
        send2(32'hFFFFF0B7, 32'hFFFFF000, FMT_U);
        repeat (3) @(posedge clk);
        #1;

        // stall: two accepted, third waits, then all three in order
        b.out_ready = 1'b0;
        fork
            begin
                send(0, 32'h0000_3000);
                send(1, 32'h0000_3004);
                send(2, 32'h0000_3008);
            end
            begin
                repeat (6) @(posedge clk);
                #1 b.out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // flush with both entries held and a new input offered
        b.out_ready = 1'b0;
        send(3, 32'h0000_4000);
        send(4, 32'h0000_4004);
        b.in_valid = 1'b1;
        b.in_instr = v_ins[5];
        b.in_pc    = 32'h0000_4008;
        b.flush    = 1'b1;
        @(posedge clk);
        #1;
        b.flush    = 1'b0;
        b.in_valid = 1'b0;
        @(posedge clk);
        #1 b.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // async reset mid-stall, asserted between edges
        b.out_ready = 1'b0;
        send(10, 32'h0000_5000);
        send(11, 32'h0000_5004);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", b.out_valid, 1'b0);
        chk("arst_out_imm", b.out_imm, 32'd0);
        chk("arst_out_fmt", b.out_fmt, FMT_R);
        chk("arst_out_illegal", b.out_illegal, 1'b0);
        chk("arst_out_pc", b.out_pc, 32'd0);
        chk("arst_in_ready", b.in_ready, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 b.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // random valid/ready soak
        soak_on = 1'b1;
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    int k;
                    int gap;
                    k   = $urandom_range(0, 11);
                    gap = $urandom_range(0, 2);
                    send(k, 32'h0001_0000 + 32'(n * 4));
                    repeat (gap) @(posedge clk);
                    #1;
                end
                soak_on = 1'b0;
            end
            begin
                while (soak_on) begin
                    b.out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                b.out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;

        chk("drain_q", 64'(q.size()), 64'd0);
        chk("drain_q2", 64'(q2.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
